// File: rtl/i2c_transaction_sequencer.sv
// Register-level I2C transaction sequencer: expands a read/write command into
// bit operations for the bit engine, runs it under a watchdog, and returns one response.
package i2c_core_pkg;
  typedef enum logic [2:0] {
    BIT_OP_START  = 3'd0,
    BIT_OP_STOP   = 3'd1,
    BIT_OP_TX_0   = 3'd2,
    BIT_OP_TX_1   = 3'd3,
    BIT_OP_RX     = 3'd4,
    BIT_OP_RX_ACK = 3'd5,
    BIT_OP_RS     = 3'd6
  } bit_op_t;

  typedef struct packed {
    logic        rw;
    logic [6:0]  dev_addr;
    logic [7:0]  reg_addr;
    logic [15:0] wr_data;
    logic        two_bytes;
  } i2c_cmd_t;
endpackage

module i2c_transaction_sequencer
  import i2c_core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rw_i,
  input  logic [6:0]  cmd_dev_addr_i,
  input  logic [7:0]  cmd_reg_addr_i,
  input  logic [15:0] cmd_wr_data_i,
  input  logic        cmd_two_bytes_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [15:0] resp_rd_data_o,
  output logic        resp_error_o,
  output bit_op_t     bit_op_o,
  output logic        push_bit_op_o,
  output logic        start_o,
  input  logic        busy_i,
  input  logic        done_i,
  input  logic        error_i,
  input  logic        rx_bit_i,
  input  logic        rx_bit_queue_empty_i,
  output logic        pull_rx_bit_o
);

  localparam int unsigned WD_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned RXC_W  = 5;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_COLLECT, S_RESP} state_t;

  function automatic bit_op_t tx_bit(input logic b);
    return b ? BIT_OP_TX_1 : BIT_OP_TX_0;
  endfunction

  // Op at list position i; positions 0..17 (address + register phase) are shared by reads and writes.
  function automatic bit_op_t op_at(input i2c_cmd_t c, input logic [IDX_W-1:0] i);
    bit_op_t    op;
    logic [7:0] b0;
    b0 = c.two_bytes ? c.wr_data[15:8] : c.wr_data[7:0];
    if (i < 6'd7)                      op = tx_bit(c.dev_addr[3'(6'd6 - i)]);
    else if (i == 6'd7)                op = BIT_OP_TX_0;
    else if (i == 6'd8 || i == 6'd17)  op = BIT_OP_RX_ACK;
    else if (i < 6'd17)                op = tx_bit(c.reg_addr[3'(6'd16 - i)]);
    else if (!c.rw) begin
      if (i == 6'd26 || i == 6'd35)    op = BIT_OP_RX_ACK;
      else if (i < 6'd26)              op = tx_bit(b0[3'(6'd25 - i)]);
      else                             op = tx_bit(c.wr_data[3'(6'd34 - i)]);
    end else begin
      if (i == 6'd18)                  op = BIT_OP_RS;
      else if (i < 6'd26)              op = tx_bit(c.dev_addr[3'(6'd25 - i)]);
      else if (i == 6'd26)             op = BIT_OP_TX_1;
      else if (i == 6'd27)             op = BIT_OP_RX_ACK;
      else if (i == 6'd36)             op = tx_bit(!c.two_bytes);
      else if (i == 6'd45)             op = BIT_OP_TX_1;
      else                             op = BIT_OP_RX;
    end
    return op;
  endfunction

  function automatic logic [IDX_W-1:0] last_idx(input i2c_cmd_t c);
    case ({c.rw, c.two_bytes})
      2'b00:   return 6'd26;
      2'b01:   return 6'd35;
      2'b10:   return 6'd36;
      default: return 6'd45;
    endcase
  endfunction

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  state_t            state_q, state_d;
  i2c_cmd_t          cmd_q, cmd_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [RXC_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_shift_n;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_error_q, resp_error_d, resp_valid_q, resp_valid_d;
  logic              push_q, push_d, start_q, start_d;
  bit_op_t           bit_op_q, bit_op_d;
  logic              cmd_hs, pull, timeout;

  // Reset asserts asynchronously, releases two edges after arstn_i rises.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Ready and pull are handshake-qualified by the current cycle's inputs, so they stay combinational.
  assign cmd_ready_o   = rst_n && (state_q == S_IDLE) && !busy_i;
  assign cmd_hs        = cmd_valid_i && cmd_ready_o;
  assign pull          = (state_q == S_COLLECT) && !rx_bit_queue_empty_i;
  assign pull_rx_bit_o = pull;
  assign timeout       = (wd_q >= WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    idx_d        = idx_q;
    wd_d         = wd_q;
    rx_cnt_d     = rx_cnt_q;
    rx_shift_d   = rx_shift_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    rx_shift_n   = {rx_shift_q[DATA_W-2:0], rx_bit_i};

    unique case (state_q)
      S_IDLE: if (cmd_hs) begin
        cmd_d.rw        = cmd_rw_i;
        cmd_d.dev_addr  = cmd_dev_addr_i;
        cmd_d.reg_addr  = cmd_reg_addr_i;
        cmd_d.wr_data   = cmd_wr_data_i;
        cmd_d.two_bytes = cmd_two_bytes_i;
        idx_d      = '0;
        wd_d       = '0;
        rx_cnt_d   = '0;
        rx_shift_d = '0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        if (idx_q == last_idx(cmd_q)) state_d = S_KICK;
        else                          idx_d   = idx_q + IDX_W'(1);
      end
      S_KICK: begin
        wd_d    = wd_q + WD_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_i && !error_i && cmd_q.rw) begin
          state_d = S_COLLECT;
        end else if (done_i || timeout) begin
          resp_error_d = error_i || !done_i;
          resp_data_d  = '0;
          state_d      = S_RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_COLLECT: begin
        if (pull && rx_cnt_q == (cmd_q.two_bytes ? RXC_W'(15) : RXC_W'(7))) begin
          resp_error_d = 1'b0;
          resp_data_d  = rx_shift_n;
          state_d      = S_RESP;
        end else if (timeout) begin
          resp_error_d = 1'b1;
          resp_data_d  = '0;
          state_d      = S_RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (pull) begin
            rx_shift_d = rx_shift_n;
            rx_cnt_d   = rx_cnt_q + RXC_W'(1);
          end
        end
      end
      S_RESP: if (resp_ready_i) begin
        resp_data_d  = '0;
        resp_error_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the next state so they line up with the state they belong to.
    push_d       = (state_d == S_LOAD);
    start_d      = (state_d == S_KICK);
    resp_valid_d = (state_d == S_RESP);
    bit_op_d     = push_d ? op_at(cmd_d, idx_d) : BIT_OP_START;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      idx_q        <= '0;
      wd_q         <= '0;
      rx_cnt_q     <= '0;
      rx_shift_q   <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      resp_valid_q <= 1'b0;
      push_q       <= 1'b0;
      start_q      <= 1'b0;
      bit_op_q     <= BIT_OP_START;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      idx_q        <= idx_d;
      wd_q         <= wd_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_shift_q   <= rx_shift_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      resp_valid_q <= resp_valid_d;
      push_q       <= push_d;
      start_q      <= start_d;
      bit_op_q     <= bit_op_d;
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_rd_data_o = resp_data_q;
  assign resp_error_o   = resp_error_q;
  assign push_bit_op_o  = push_q;
  assign start_o        = start_q;
  assign bit_op_o       = bit_op_q;

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Bench for i2c_transaction_sequencer: plays the bit engine, checks op lists,
// responses and handshakes against a byte-level reference model.
module tb_i2c_transaction_sequencer;
  import i2c_core_pkg::*;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_rw_i = 1'b0;
  logic [6:0]  cmd_dev_addr_i = '0;
  logic [7:0]  cmd_reg_addr_i = '0;
  logic [15:0] cmd_wr_data_i = '0;
  logic        cmd_two_bytes_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [15:0] resp_rd_data_o;
  logic        resp_error_o;
  bit_op_t     bit_op_o;
  logic        push_bit_op_o;
  logic        start_o;
  logic        busy_i = 1'b0;
  logic        done_i = 1'b0;
  logic        error_i = 1'b0;
  logic        rx_bit_i = 1'b0;
  logic        rx_bit_queue_empty_i = 1'b1;
  logic        pull_rx_bit_o;

  i2c_transaction_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_rw_i(cmd_rw_i),
    .cmd_dev_addr_i(cmd_dev_addr_i), .cmd_reg_addr_i(cmd_reg_addr_i),
    .cmd_wr_data_i(cmd_wr_data_i), .cmd_two_bytes_i(cmd_two_bytes_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rd_data_o(resp_rd_data_o), .resp_error_o(resp_error_o),
    .bit_op_o(bit_op_o), .push_bit_op_o(push_bit_op_o), .start_o(start_o),
    .busy_i(busy_i), .done_i(done_i), .error_i(error_i),
    .rx_bit_i(rx_bit_i), .rx_bit_queue_empty_i(rx_bit_queue_empty_i),
    .pull_rx_bit_o(pull_rx_bit_o)
  );

  always #5 clk_i = ~clk_i;

  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  bit_op_t ops_cap[$];
  bit_op_t exp_ops[$];
  bit      rxq[$];
  int      starts = 0;
  int      pulls = 0;
  int      first_push = 0;
  int      last_push = 0;
  bit      pull_seen;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Engine stand-in: records pushes/starts/pulls mid-cycle, pops the rx queue after the edge that consumed it.
  always begin
    @(negedge clk_i);
    if (push_bit_op_o) begin
      if (ops_cap.size() == 0) first_push = cyc;
      last_push = cyc;
      ops_cap.push_back(bit_op_o);
    end
    if (start_o) starts = starts + 1;
    pull_seen = pull_rx_bit_o;
    if (pull_seen) pulls = pulls + 1;
    @(posedge clk_i);
    #1;
    if (pull_seen && rxq.size() > 0) void'(rxq.pop_front());
    rx_bit_queue_empty_i = (rxq.size() == 0);
    rx_bit_i = (rxq.size() != 0) ? rxq[0] : 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) exp_ops.push_back(b[k] ? BIT_OP_TX_1 : BIT_OP_TX_0);
  endtask

  // Reference op list built byte by byte from the command.
  task automatic build_exp(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [15:0] wd, input logic two);
    int nb;
    exp_ops.delete();
    nb = two ? 2 : 1;
    add_byte({dev, 1'b0}); exp_ops.push_back(BIT_OP_RX_ACK);
    add_byte(rg);          exp_ops.push_back(BIT_OP_RX_ACK);
    if (!rw) begin
      if (two) begin add_byte(wd[15:8]); exp_ops.push_back(BIT_OP_RX_ACK); end
      add_byte(wd[7:0]); exp_ops.push_back(BIT_OP_RX_ACK);
    end else begin
      exp_ops.push_back(BIT_OP_RS);
      add_byte({dev, 1'b1}); exp_ops.push_back(BIT_OP_RX_ACK);
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < 8; k++) exp_ops.push_back(BIT_OP_RX);
        exp_ops.push_back((b == nb - 1) ? BIT_OP_TX_1 : BIT_OP_TX_0);
      end
    end
  endtask

  task automatic send_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [15:0] wd, input logic two);
    int n;
    ops_cap.delete(); starts = 0; pulls = 0;
    cmd_rw_i = rw; cmd_dev_addr_i = dev; cmd_reg_addr_i = rg;
    cmd_wr_data_i = wd; cmd_two_bytes_i = two; cmd_valid_i = 1'b1;
    n = 0;
    while (!cmd_ready_o && n < 20) begin @(negedge clk_i); n++; end
    chk("cmd_ready_seen", 64'(cmd_ready_o), 64'd1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    busy_i = 1'b1;
  endtask

  task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [15:0] wd, input logic two, input logic eng_err,
                         input logic no_done, input logic [7:0] rb0, input logic [7:0] rb1,
                         input int resp_delay);
    int          n, start_cyc, exp_pulls;
    logic [15:0] exp_data;
    logic        exp_err;
    build_exp(rw, dev, rg, wd, two);
    exp_err   = eng_err || no_done;
    exp_data  = (exp_err || !rw) ? 16'h0000 : (two ? {rb0, rb1} : {8'h00, rb0});
    exp_pulls = (exp_err || !rw) ? 0 : (two ? 16 : 8);
    send_cmd(rw, dev, rg, wd, two);
    n = 0;
    while (!start_o && n < 80) begin @(negedge clk_i); n++; end
    chk("start_seen", 64'(start_o), 64'd1);
    start_cyc = cyc;
    if (rw && !exp_err) begin
      for (int k = 7; k >= 0; k--) rxq.push_back(rb0[k]);
      if (two) for (int k = 7; k >= 0; k--) rxq.push_back(rb1[k]);
    end
    if (!no_done) begin
      repeat ($urandom_range(1, 8)) @(negedge clk_i);
      done_i = 1'b1; error_i = eng_err;
      @(negedge clk_i);
      done_i = 1'b0; error_i = 1'b0; busy_i = 1'b0;
    end
    n = 0;
    while (!resp_valid_o && n < 250) begin @(negedge clk_i); n++; end
    chk("resp_valid_seen", 64'(resp_valid_o), 64'd1);
    if (no_done) chk("timeout_latency", 64'(cyc - start_cyc), 64'd100);
    busy_i = 1'b0;
    chk("resp_data", 64'(resp_rd_data_o), 64'(exp_data));
    chk("resp_error", 64'(resp_error_o), 64'(exp_err));
    for (int k = 0; k < resp_delay; k++) begin
      @(negedge clk_i);
      chk("resp_stall", 64'({resp_valid_o, resp_rd_data_o, resp_error_o, cmd_ready_o}),
          64'({1'b1, exp_data, exp_err, 1'b0}));
    end
    resp_ready_i = 1'b1;
    chk("ready_in_hs_cycle", 64'(cmd_ready_o), 64'd0);
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    chk("post_hs_valid_ready", 64'({resp_valid_o, cmd_ready_o}), 64'b01);
    chk("start_count", 64'(starts), 64'd1);
    chk("pull_count", 64'(pulls), 64'(exp_pulls));
    chk("op_count", 64'(ops_cap.size()), 64'(exp_ops.size()));
    for (int i = 0; i < exp_ops.size() && i < ops_cap.size(); i++)
      chk($sformatf("op[%0d]", i), 64'(ops_cap[i]), 64'(exp_ops[i]));
    chk("push_contiguous", 64'(last_push - first_push + 1), 64'(ops_cap.size()));
    chk("start_after_last_push", 64'(start_cyc), 64'(last_push + 1));
  endtask

  initial begin
    repeat (50000) @(posedge clk_i);
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic        rw, two, eerr, nd;
    logic [6:0]  dev;
    logic [7:0]  rg, b0, b1;
    logic [15:0] wd;

    repeat (3) @(negedge clk_i);
    chk("reset_outputs", 64'({cmd_ready_o, resp_valid_o, resp_error_o, push_bit_op_o,
                              start_o, pull_rx_bit_o, resp_rd_data_o}), 64'd0);
    arstn_i = 1'b1;
    repeat (4) @(negedge clk_i);
    busy_i = 1'b1; #1;
    chk("ready_gated_by_busy", 64'(cmd_ready_o), 64'd0);
    busy_i = 1'b0; #1;
    chk("ready_when_idle", 64'(cmd_ready_o), 64'd1);
    @(negedge clk_i);

    run_txn(1'b0, 7'h50, 8'h10, 16'h00A5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    run_txn(1'b1, 7'h50, 8'h02, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 0);
    run_txn(1'b0, 7'h3C, 8'h81, 16'hBEEF, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1);
    run_txn(1'b0, 7'h21, 8'h44, 16'h1234, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 0);
    run_txn(1'b1, 7'h7F, 8'hFF, 16'h0000, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h00, 50);
    run_txn(1'b1, 7'h0A, 8'h55, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h99, 8'h66, 2);

    // Abort mid-load: reset must clear everything at once and leave no response behind.
    send_cmd(1'b0, 7'h50, 8'h10, 16'h00A5, 1'b0);
    repeat (10) @(negedge clk_i);
    chk("push_at_op10", 64'(push_bit_op_o), 64'd1);
    #2 arstn_i = 1'b0;
    #1 chk("async_reset_outputs", 64'({cmd_ready_o, resp_valid_o, resp_error_o, push_bit_op_o,
                                       start_o, pull_rx_bit_o, resp_rd_data_o}), 64'd0);
    busy_i = 1'b0;
    repeat (3) @(negedge clk_i);
    arstn_i = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("no_start_after_abort", 64'(starts), 64'd0);
    chk("no_resp_after_abort", 64'({resp_valid_o, cmd_ready_o}), 64'b01);
    run_txn(1'b0, 7'h50, 8'h10, 16'h00A5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0);

    for (int t = 0; t < 16; t++) begin
      rw   = 1'($urandom);
      two  = 1'($urandom);
      dev  = 7'($urandom);
      rg   = 8'($urandom);
      wd   = 16'($urandom);
      b0   = 8'($urandom);
      b1   = 8'($urandom);
      eerr = ($urandom_range(0, 3) == 0);
      nd   = !eerr && ($urandom_range(0, 7) == 0);
      run_txn(rw, dev, rg, wd, two, eerr, nd, b0, b1, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
